// File: rtl/core_ifetch_prefetch.sv
// core_ifetch_prefetch: RV32I sequential-prefetch instruction fetch front end.
// Issues AXI4-Lite reads ahead of decode, buffers returned words with their PCs,
// and supports FLUSH redirects that discard stale in-flight responses.
// Optional feature macro: IFETCH_ERR_EN (flag non-OKAY responses, halt issue until FLUSH).
module core_ifetch_prefetch #(
    parameter logic [31:0] PC_INIT         = 32'h0,
    parameter int unsigned AXI_AWIDTH      = 32,
    parameter int unsigned AXI_DWIDTH      = 32,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    output logic [AXI_AWIDTH-1:0] o_axi_araddr,
    output logic                  o_axi_arvalid,
    input  logic                  i_axi_arready,
    input  logic [AXI_DWIDTH-1:0] i_axi_rdata,
    input  logic [1:0]            i_axi_rresp,
    input  logic                  i_axi_rvalid,
    output logic                  o_axi_rready,
    output logic [31:0]           o_instr,
    output logic [31:0]           o_instr_pc,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready,
    output logic                  o_instr_err,
    input  logic                  i_flush,
    input  logic [31:0]           i_pc_next,
    output logic                  o_busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 2;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXOUT_C = CW'(MAX_OUTSTANDING);

    // architectural state
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_ar_pc;
    logic          r_arvalid;
    logic          r_ar_stale;
    logic          r_rready;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_disc;
    logic [CW-1:0] r_fifo_cnt;
    logic [PW-1:0] r_fifo_rd;
    logic [PW-1:0] r_fifo_wr;
    logic [PW-1:0] r_tag_rd;
    logic [PW-1:0] r_tag_wr;

    // storage (no reset needed: guarded by counters/pointers)
    logic [31:0]   r_fifo_data [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]   r_tag_pc    [FIFO_DEPTH];

    // next-state and event wires
    logic          w_ar_hs;
    logic          w_hs_live;
    logic          w_hs_stale;
    logic          w_tag_push;
    logic          w_r_beat;
    logic          w_r_drop;
    logic          w_r_live;
    logic          w_push;
    logic          w_pop;
    logic          w_hold;
    logic          w_err_in;
    logic          w_halt_n;
    logic [31:0]   w_rdata;
    logic [31:0]   w_fetch_pc_n;
    logic [31:0]   w_ar_pc_n;
    logic          w_arvalid_n;
    logic          w_stale_n;
    logic [CW-1:0] w_out_n;
    logic [CW-1:0] w_disc_n;
    logic [CW-1:0] w_fifo_cnt_n;

    assign w_rdata    = i_axi_rdata[31:0];
    assign w_ar_hs    = r_arvalid & i_axi_arready;
    assign w_hs_live  = w_ar_hs & ~r_ar_stale;
    assign w_hs_stale = w_ar_hs & r_ar_stale;
    assign w_tag_push = w_hs_live & ~i_flush;
    assign w_r_beat   = i_axi_rvalid & r_rready;
    assign w_r_drop   = w_r_beat & (r_disc != '0);
    assign w_r_live   = w_r_beat & (r_disc == '0);
    assign w_push     = w_r_live & ~i_flush;
    assign w_pop      = o_instr_valid & i_instr_ready & ~i_flush;
    assign w_hold     = r_arvalid & ~i_axi_arready;

`ifdef IFETCH_ERR_EN
    logic r_halt;
    logic r_fifo_err [FIFO_DEPTH];

    assign w_err_in    = (i_axi_rresp != 2'b00);
    assign o_instr_err = o_instr_valid & r_fifo_err[r_fifo_rd];

    // issue halt: set by a buffered error beat, released by redirect
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_halt <= 1'b0;
        end else begin
            r_halt <= w_halt_n;
        end
    end

    // error flag storage alongside each buffered word
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_err[r_fifo_wr] <= w_err_in;
        end
    end
`else
    logic w_unused_rresp;

    assign w_unused_rresp = ^i_axi_rresp;
    assign w_err_in       = 1'b0;
    assign o_instr_err    = 1'b0;
`endif

    // next-state: credit counters, fetch address and AR issue decision
    always_comb begin
        w_out_n      = r_out + CW'(w_hs_live) - CW'(w_r_live);
        w_disc_n     = r_disc + CW'(w_hs_stale) - CW'(w_r_drop);
        w_fifo_cnt_n = r_fifo_cnt + CW'(w_push) - CW'(w_pop);
        w_fetch_pc_n = w_hs_live ? (r_fetch_pc + 32'd4) : r_fetch_pc;
        w_halt_n     = 1'b0;
        w_stale_n    = 1'b0;

`ifdef IFETCH_ERR_EN
        w_halt_n = r_halt | (w_push & w_err_in);
`endif

        // redirect: everything still in flight becomes discard credit
        if (i_flush) begin
            w_disc_n     = w_disc_n + w_out_n;
            w_out_n      = '0;
            w_fifo_cnt_n = '0;
            w_fetch_pc_n = i_pc_next;
            w_halt_n     = 1'b0;
        end

        // a pending AR stays stable; a flush while pending marks it stale
        if (w_hold) begin
            w_stale_n   = r_ar_stale | i_flush;
            w_arvalid_n = 1'b1;
            w_ar_pc_n   = r_ar_pc;
        end else begin
            w_arvalid_n = ~w_halt_n
                        & ((w_fifo_cnt_n + w_out_n + w_disc_n) < DEPTH_C)
                        & (w_out_n < MAXOUT_C);
            w_ar_pc_n   = w_fetch_pc_n;
        end
    end

    // state register with async reset
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_fetch_pc <= PC_INIT;
            r_ar_pc    <= PC_INIT;
            r_arvalid  <= 1'b0;
            r_ar_stale <= 1'b0;
            r_rready   <= 1'b0;
            r_out      <= '0;
            r_disc     <= '0;
            r_fifo_cnt <= '0;
            r_fifo_rd  <= '0;
            r_fifo_wr  <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_n;
            r_ar_pc    <= w_ar_pc_n;
            r_arvalid  <= w_arvalid_n;
            r_ar_stale <= w_stale_n;
            r_rready   <= 1'b1;
            r_out      <= w_out_n;
            r_disc     <= w_disc_n;
            r_fifo_cnt <= w_fifo_cnt_n;
            if (i_flush) begin
                r_fifo_rd <= '0;
                r_fifo_wr <= '0;
                r_tag_rd  <= '0;
                r_tag_wr  <= '0;
            end else begin
                if (w_push)     r_fifo_wr <= r_fifo_wr + PW'(1);
                if (w_pop)      r_fifo_rd <= r_fifo_rd + PW'(1);
                if (w_tag_push) r_tag_wr  <= r_tag_wr + PW'(1);
                if (w_push)     r_tag_rd  <= r_tag_rd + PW'(1);
            end
        end
    end

    // tag queue of issued PCs and instruction buffer payload
    always_ff @(posedge i_clk) begin
        if (w_tag_push) begin
            r_tag_pc[r_tag_wr] <= r_ar_pc;
        end
        if (w_push) begin
            r_fifo_data[r_fifo_wr] <= w_rdata;
            r_fifo_pc[r_fifo_wr]   <= r_tag_pc[r_tag_rd];
        end
    end

    assign o_axi_araddr  = AXI_AWIDTH'(r_ar_pc);
    assign o_axi_arvalid = r_arvalid;
    assign o_axi_rready  = r_rready;
    assign o_instr       = r_fifo_data[r_fifo_rd];
    assign o_instr_pc    = r_fifo_pc[r_fifo_rd];
    assign o_instr_valid = (r_fifo_cnt != '0);
    assign o_busy        = (r_out != '0) | (r_disc != '0);

endmodule

// File: tb/tb_core_ifetch_prefetch.sv
// Bench for core_ifetch_prefetch: randomized AXI slave + decode traffic, checked
// every cycle against a transaction-level model (queues of in-flight reads and
// buffered instructions), plus directed redirect/backpressure/reset scenarios.
module tb_core_ifetch_prefetch;

    localparam int DEPTH  = 4;
    localparam int MAXOUT = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        instr_err;
    logic        flush;
    logic [31:0] pc_next;
    logic        busy;

    core_ifetch_prefetch dut (
        .i_clk         (clk),
        .i_nrst        (rst_n),
        .o_axi_araddr  (araddr),
        .o_axi_arvalid (arvalid),
        .i_axi_arready (arready),
        .i_axi_rdata   (rdata),
        .i_axi_rresp   (rresp),
        .i_axi_rvalid  (rvalid),
        .o_axi_rready  (rready),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .o_instr_err   (instr_err),
        .i_flush       (flush),
        .i_pc_next     (pc_next),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } ent_t;
    typedef struct { logic [31:0] pc; bit stale; } fl_t;
    typedef struct { logic [31:0] addr; int due; logic [1:0] resp; } sr_t;

    // model state
    ent_t        q_instr[$];
    fl_t         q_fl[$];
    sr_t         q_sl[$];
    logic [31:0] m_pc;
    bit          m_pending;
    bit          m_pend_stale;
    logic [31:0] m_pend_addr;
    bit          m_halt;
    logic [31:0] pops[$];
    logic [31:0] ar_log[$];

    // stimulus knobs
    int          ready_pct, arready_pct, flush_pct, dly_max, err_pct;
    bit          force_flush;
    logic [31:0] force_pc;
    bit          err_addr_en;
    logic [31:0] err_addr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        q_instr.delete();
        q_fl.delete();
        q_sl.delete();
        m_pc         = 32'h0;
        m_pending    = 0;
        m_pend_stale = 0;
        m_pend_addr  = 32'h0;
        m_halt       = 0;
    endtask

    task automatic drive_idle();
        arready     = 1'b0;
        rvalid      = 1'b0;
        rdata       = 32'h0;
        rresp       = 2'b00;
        instr_ready = 1'b0;
        flush       = 1'b0;
        pc_next     = 32'h0;
    endtask

    // asynchronous reset between clock edges; outputs must clear at once
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        drive_idle();
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_instr_err", 32'(instr_err), 32'd0);
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one clock: compare outputs with model, pick inputs, advance model over the coming edge
    task automatic step();
        bit          exp_arv, hs_m, hs_d, fl, pop, is_err;
        logic [31:0] exp_addr;
        int          nonstale;
        ent_t        e;
        fl_t         f;
        sr_t         s;
        @(negedge clk);
        cyc++;
        nonstale = 0;
        for (int i = 0; i < q_fl.size(); i++) if (!q_fl[i].stale) nonstale++;
        exp_arv  = m_pending || (!m_halt && (q_instr.size() + q_fl.size() < DEPTH) && (nonstale < MAXOUT));
        exp_addr = m_pending ? m_pend_addr : m_pc;

        chk("arvalid", 32'(arvalid), 32'(exp_arv));
        if (exp_arv) chk("araddr", araddr, exp_addr);
        chk("rready", 32'(rready), 32'd1);
        chk("busy", 32'(busy), 32'(q_fl.size() != 0));
        chk("instr_valid", 32'(instr_valid), 32'(q_instr.size() != 0));
        if (q_instr.size() != 0) begin
            chk("instr_pc", instr_pc, q_instr[0].pc);
            chk("instr", instr, q_instr[0].data);
            chk("instr_err", 32'(instr_err), 32'(q_instr[0].err));
        end

        instr_ready = ($urandom_range(99) < ready_pct);
        arready     = ($urandom_range(99) < arready_pct);
        fl          = force_flush || ($urandom_range(99) < flush_pct);
        flush       = fl;
        if (force_flush) pc_next = force_pc;
        else if ($urandom_range(7) == 0) pc_next = $urandom;
        else pc_next = $urandom & 32'hFFFF_FFFC;
        force_flush = 0;
        if (q_sl.size() != 0 && q_sl[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem(q_sl[0].addr);
            rresp  = q_sl[0].resp;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'($urandom);
        end

        hs_m = exp_arv && arready;
        hs_d = arvalid && arready;
        pop  = instr_ready && (q_instr.size() != 0) && !fl;
        if (pop) begin
            pops.push_back(q_instr[0].pc);
            void'(q_instr.pop_front());
        end
        if (rvalid) begin
            s = q_sl.pop_front();
            if (q_fl.size() == 0) begin
                chk("r_beat_without_ar", 32'd1, 32'd0);
            end else begin
                f = q_fl.pop_front();
`ifdef IFETCH_ERR_EN
                is_err = (s.resp != 2'b00);
`else
                is_err = 0;
`endif
                if (!f.stale && !fl) begin
                    e.pc = f.pc; e.data = mem(f.pc); e.err = is_err;
                    q_instr.push_back(e);
                    if (is_err) m_halt = 1;
                end
            end
        end
        if (hs_d) begin
            s.addr = araddr;
            s.due  = cyc + 1 + $urandom_range(dly_max);
            if (err_addr_en && araddr == err_addr) s.resp = 2'b10;
            else if ($urandom_range(99) < err_pct) s.resp = 2'($urandom_range(3, 1));
            else s.resp = 2'b00;
            q_sl.push_back(s);
            ar_log.push_back(araddr);
        end
        if (hs_m) begin
            f.pc = exp_addr; f.stale = m_pend_stale || fl;
            q_fl.push_back(f);
            if (!m_pend_stale) m_pc = exp_addr + 32'd4;
        end
        m_pending   = exp_arv && !arready;
        m_pend_addr = exp_addr;
        if (!m_pending) m_pend_stale = 0;
        if (fl) begin
            q_instr.delete();
            for (int i = 0; i < q_fl.size(); i++) q_fl[i].stale = 1;
            m_pc   = pc_next;
            m_halt = 0;
            if (m_pending) m_pend_stale = 1;
        end
    endtask

    task automatic knobs(input int rdy, input int arr, input int flp, input int dly, input int erp);
        ready_pct = rdy; arready_pct = arr; flush_pct = flp; dly_max = dly; err_pct = erp;
    endtask

    int mark;

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_clear();
        force_flush = 0; force_pc = 0; err_addr_en = 0; err_addr = 0;
        knobs(0, 0, 0, 0, 0);

        // streaming: one instruction per cycle after fill
        do_reset();
        knobs(100, 100, 0, 0, 0);
        repeat (14) step();
        chk("s1_pop0", pops[0], 32'h0);
        chk("s1_pop1", pops[1], 32'h4);
        chk("s1_pop2", pops[2], 32'h8);
        chk("s1_pop3", pops[3], 32'hC);
        chk("s1_rate", 32'(pops.size() >= 10), 32'd1);

        // decode stall: buffer limits issue to FIFO_DEPTH reads
        do_reset();
        pops.delete(); ar_log.delete();
        knobs(0, 100, 0, 0, 0);
        repeat (10) step();
        chk("s2_ar_count", 32'(ar_log.size()), 32'd4);
        chk("s2_arvalid_low", 32'(arvalid), 32'd0);
        knobs(100, 0, 0, 0, 0);
        repeat (5) step();
        chk("s2_pop0", pops[0], 32'h0);
        chk("s2_pop3", pops[3], 32'hC);

        // flush with reads outstanding
        do_reset();
        pops.delete();
        knobs(0, 100, 0, 2, 0);
        repeat (3) step();
        knobs(0, 0, 0, 2, 0);
        force_flush = 1; force_pc = 32'h100;
        step();
        mark = pops.size();
        repeat (6) step();
        chk("s3_busy_drained", 32'(busy), 32'd0);
        knobs(100, 100, 0, 0, 0);
        repeat (12) step();
        chk("s3_first_after_flush", pops[mark], 32'h100);

        // flush while an AR waits for ARREADY
        do_reset();
        pops.delete(); ar_log.delete();
        knobs(0, 0, 0, 0, 0);
        repeat (3) step();
        force_flush = 1; force_pc = 32'h200;
        step();
        repeat (3) step();
        chk("s4_araddr_held", araddr, 32'h0);
        chk("s4_arvalid_held", 32'(arvalid), 32'd1);
        mark = pops.size();
        knobs(100, 100, 0, 0, 0);
        repeat (10) step();
        chk("s4_ar0", ar_log[0], 32'h0);
        chk("s4_ar1", ar_log[1], 32'h200);
        chk("s4_first_pop", pops[mark], 32'h200);

        // flush coinciding with an R beat and a pop
        do_reset();
        pops.delete();
        knobs(100, 100, 0, 0, 0);
        repeat (8) step();
        force_flush = 1; force_pc = 32'h300;
        step();
        mark = pops.size();
        @(posedge clk); #1;
        chk("s5_valid_after_flush", 32'(instr_valid), 32'd0);
        repeat (8) step();
        chk("s5_first_pop", pops[mark], 32'h300);

        // address wrap at 2^32
        do_reset();
        pops.delete();
        knobs(100, 100, 0, 0, 0);
        force_flush = 1; force_pc = 32'hFFFF_FFF8;
        step();
        mark = pops.size();
        repeat (10) step();
        chk("wrap_pop0", pops[mark], 32'hFFFF_FFF8);
        chk("wrap_pop1", pops[mark + 1], 32'hFFFF_FFFC);
        chk("wrap_pop2", pops[mark + 2], 32'h0);

`ifdef IFETCH_ERR_EN
        // error response halts issue until redirect
        do_reset();
        pops.delete();
        err_addr_en = 1; err_addr = 32'h8;
        knobs(0, 100, 0, 0, 0);
        repeat (15) step();
        chk("e_arvalid_halt", 32'(arvalid), 32'd0);
        knobs(100, 100, 0, 0, 0);
        repeat (2) step();
        knobs(0, 100, 0, 0, 0);
        @(posedge clk); #1;
        chk("e_head_pc", instr_pc, 32'h8);
        chk("e_head_err", 32'(instr_err), 32'd1);
        knobs(100, 100, 0, 0, 0);
        repeat (10) step();
        chk("e_still_halted", 32'(arvalid), 32'd0);
        force_flush = 1; force_pc = 32'h40;
        step();
        mark = pops.size();
        repeat (8) step();
        chk("e_resume", pops[mark], 32'h40);
        err_addr_en = 0;
`endif

        // randomized traffic with a mid-run asynchronous reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            knobs(int'($urandom_range(100)), int'($urandom_range(20, 100)), 3,
                  int'($urandom_range(3)), 10);
            if (i == 1500) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
